// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg
// Shared definitions for the instruction fetch unit: FSM state encoding,
// status register bit positions and the instruction word width.
package instr_fetch_unit_pkg;

    localparam int INSTR_W = 16;

    // Bit positions inside the 4-bit status register (status[0] is Z).
    localparam int STATUS_Z = 0;
    localparam int STATUS_N = 1;
    localparam int STATUS_C = 2;
    localparam int STATUS_V = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_HALT  = 3'd3,
        ST_ERR   = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_status_reg.sv
// instr_fetch_unit_status_reg
// 4-bit V,C,N,Z status register, loaded whenever we=1 regardless of what
// the fetch FSM is doing.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (clears to 0)
//   we           : load enable
//   d            : flags from the function unit
//   q            : registered status, visible the cycle after the write
module instr_fetch_unit_status_reg (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       we,
    input  logic [3:0] d,
    output logic [3:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= 4'b0000;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Front end of the control unit. Owns the PC, fetches 16-bit instructions
// over a req/ack handshake, holds IR for decode until the datapath reports
// completion, applies branch/jump redirects and parks on halt or on a
// memory timeout.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   mem_req, mem_addr     : fetch request and address (decoded from state)
//   mem_ack, mem_rdata    : fetch response
//   ir, ir_valid, pc      : instruction register, its valid flag, current PC
//   ex_done, pc_load,
//   pc_target, halt       : completion of the instruction in ir (+ redirect)
//   flags_in, status_we,
//   status                : status register write port and value
//   fetch_err, halted     : sticky timeout fault, halt indication
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                     PC_WIDTH    = 16,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter int                     MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic                mem_req,
    output logic [PC_WIDTH-1:0] mem_addr,
    input  logic                mem_ack,
    input  logic [INSTR_W-1:0]  mem_rdata,
    output logic [INSTR_W-1:0]  ir,
    output logic                ir_valid,
    output logic [PC_WIDTH-1:0] pc,
    input  logic                ex_done,
    input  logic                pc_load,
    input  logic [PC_WIDTH-1:0] pc_target,
    input  logic                halt,
    input  logic [3:0]          flags_in,
    input  logic                status_we,
    output logic [3:0]          status,
    output logic                fetch_err,
    output logic                halted
);

    fetch_state_t state;
    logic [7:0]   tmo_cnt;

    // The counter holds the number of REQ cycles already waited, so the
    // cycle on which it equals MEM_TIMEOUT-1 is the MEM_TIMEOUT-th one.
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    // Decoded so the request drops the instant reset asserts.
    assign mem_req  = (state == ST_REQ);
    assign mem_addr = mem_req ? pc : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            ir        <= '0;
            ir_valid  <= 1'b0;
            tmo_cnt   <= '0;
            fetch_err <= 1'b0;
            halted    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tmo_cnt <= '0;
                    state   <= ST_REQ;
                end
                ST_REQ: begin
                    // An ack on the timeout cycle still completes the fetch.
                    if (mem_ack) begin
                        ir       <= mem_rdata;
                        pc       <= pc + PC_WIDTH'(1);
                        ir_valid <= 1'b1;
                        tmo_cnt  <= '0;
                        state    <= ST_ISSUE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        fetch_err <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= ST_ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                ST_ISSUE: begin
                    if (ex_done) begin
                        ir_valid <= 1'b0;
                        if (pc_load) begin
                            pc <= pc_target;
                        end
                        if (halt) begin
                            halted <= 1'b1;
                            state  <= ST_HALT;
                        end else begin
                            state <= ST_REQ;
                        end
                    end
                end
                ST_HALT: state <= ST_HALT;
                ST_ERR:  state <= ST_ERR;
                default: state <= ST_IDLE;
            endcase
        end
    end

    instr_fetch_unit_status_reg u_status (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (status_we),
        .d       (flags_in),
        .q       (status)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] ir;
    logic        ir_valid;
    logic [15:0] pc;
    logic        ex_done;
    logic        pc_load;
    logic [15:0] pc_target;
    logic        halt;
    logic [3:0]  flags_in;
    logic        status_we;
    logic [3:0]  status;
    logic        fetch_err;
    logic        halted;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .PC_WIDTH    (16),
        .RESET_PC    (16'h0000),
        .MEM_TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .pc        (pc),
        .ex_done   (ex_done),
        .pc_load   (pc_load),
        .pc_target (pc_target),
        .halt      (halt),
        .flags_in  (flags_in),
        .status_we (status_we),
        .status    (status),
        .fetch_err (fetch_err),
        .halted    (halted)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the unit is doing (dead cycle, waiting on
    // memory, holding an instruction, parked) and the architectural values.
    bit        m_dead = 1'b1, m_fetching = 1'b0, m_valid = 1'b0, m_halt = 1'b0, m_err = 1'b0;
    int        m_wait = 0;
    logic [15:0] m_pc = 16'h0000, m_ir = 16'h0000;
    logic [3:0]  m_status = 4'h0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_dead <= 1'b1; m_fetching <= 1'b0; m_valid <= 1'b0;
            m_halt <= 1'b0; m_err <= 1'b0; m_wait <= 0;
            m_pc <= 16'h0000; m_ir <= 16'h0000; m_status <= 4'h0;
        end else begin
            if (status_we) m_status <= flags_in;
            if (m_dead) begin
                m_dead <= 1'b0;
                m_fetching <= 1'b1;
                m_wait <= 0;
            end else if (m_fetching) begin
                if (mem_ack) begin
                    m_ir <= mem_rdata;
                    m_pc <= m_pc + 16'd1;
                    m_valid <= 1'b1;
                    m_fetching <= 1'b0;
                    m_wait <= 0;
                end else if (m_wait + 1 >= TMO) begin
                    m_err <= 1'b1;
                    m_fetching <= 1'b0;
                end else begin
                    m_wait <= m_wait + 1;
                end
            end else if (m_valid && ex_done) begin
                m_valid <= 1'b0;
                if (pc_load) m_pc <= pc_target;
                if (halt) m_halt <= 1'b1;
                else begin
                    m_fetching <= 1'b1;
                    m_wait <= 0;
                end
            end
        end
    end

    // Every-cycle comparison on the falling edge.
    always @(negedge clk) begin
        chk("mem_req",   {31'd0, mem_req},   {31'd0, m_fetching});
        chk("mem_addr",  {16'd0, mem_addr},  m_fetching ? {16'd0, m_pc} : 32'd0);
        chk("ir",        {16'd0, ir},        {16'd0, m_ir});
        chk("ir_valid",  {31'd0, ir_valid},  {31'd0, m_valid});
        chk("pc",        {16'd0, pc},        {16'd0, m_pc});
        chk("status",    {28'd0, status},    {28'd0, m_status});
        chk("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
        chk("halted",    {31'd0, halted},    {31'd0, m_halt});
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fetch(input logic [15:0] data);
        mem_ack = 1'b1; mem_rdata = data;
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic done(input logic ld, input logic [15:0] tgt, input logic hlt);
        ex_done = 1'b1; pc_load = ld; pc_target = tgt; halt = hlt;
        tick();
        ex_done = 1'b0; pc_load = 1'b0; halt = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0; ex_done = 1'b0;
        pc_load = 1'b0; pc_target = 16'h0; halt = 1'b0; flags_in = 4'h0; status_we = 1'b0;
        tick(2);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_pc", {16'd0, pc}, 32'h0000);
        chk("rst_ir", {16'd0, ir}, 32'h0000);

        // First fetch, ack on the first REQ cycle.
        reset_n = 1'b1;
        chk("dead_cycle", {31'd0, mem_req}, 32'd0);
        tick();
        chk("req1", {31'd0, mem_req}, 32'd1);
        chk("req1_addr", {16'd0, mem_addr}, 32'h0000);
        fetch(16'hC0A5);
        chk("ir_c0a5", {16'd0, ir}, 32'hC0A5);
        chk("ir_valid1", {31'd0, ir_valid}, 32'd1);
        chk("pc1", {16'd0, pc}, 32'h0001);
        done(1'b0, 16'h0, 1'b0);
        chk("addr1", {16'd0, mem_addr}, 32'h0001);
        chk("ir_valid_drop", {31'd0, ir_valid}, 32'd0);

        // Reach pc=5, write status in ISSUE, then redirect to 0x0040.
        fetch(16'h1111);
        done(1'b1, 16'h0004, 1'b0);
        fetch(16'h2222);
        chk("pc5", {16'd0, pc}, 32'h0005);
        status_we = 1'b1; flags_in = 4'b0001;
        tick();
        status_we = 1'b0;
        chk("status_z", {28'd0, status}, 32'h1);
        chk("ir_held", {16'd0, ir}, 32'h2222);
        done(1'b1, 16'h0040, 1'b0);
        chk("redirect", {16'd0, mem_addr}, 32'h0040);

        // PC wrap from 0xFFFF.
        fetch(16'h1234);
        done(1'b1, 16'hFFFF, 1'b0);
        chk("addr_ffff", {16'd0, mem_addr}, 32'hFFFF);
        fetch(16'h5A5A);
        chk("pc_wrap", {16'd0, pc}, 32'h0000);
        done(1'b0, 16'h0, 1'b0);
        chk("addr_wrap", {16'd0, mem_addr}, 32'h0000);

        // Ack exactly on the 15th REQ cycle: no error.
        tick(TMO - 1);
        chk("wait14_req", {31'd0, mem_req}, 32'd1);
        fetch(16'h0BEE);
        chk("late15_ir", {16'd0, ir}, 32'h0BEE);
        chk("late15_err", {31'd0, fetch_err}, 32'd0);

        // Halt with redirect still applied; stays parked.
        done(1'b1, 16'h0100, 1'b1);
        chk("halted", {31'd0, halted}, 32'd1);
        chk("halt_pc", {16'd0, pc}, 32'h0100);
        status_we = 1'b1; flags_in = 4'b1010;
        tick();
        status_we = 1'b0;
        chk("halt_status", {28'd0, status}, 32'hA);
        repeat (20) begin
            ex_done = 1'b1;
            tick();
            chk("halt_no_req", {31'd0, mem_req}, 32'd0);
        end
        ex_done = 1'b0;

        // Async reset while mem_req is high.
        #2 reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        status_we = 1'b1; flags_in = 4'b0110;
        tick();
        status_we = 1'b0;
        chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
        chk("pre_rst_status", {28'd0, status}, 32'h6);
        #3 reset_n = 1'b0;
        #1;
        chk("async_req", {31'd0, mem_req}, 32'd0);
        chk("async_pc", {16'd0, pc}, 32'h0000);
        chk("async_status", {28'd0, status}, 32'h0);
        tick();
        reset_n = 1'b1;
        chk("idle_again", {31'd0, mem_req}, 32'd0);
        tick();

        // Timeout: no ack for 15 REQ cycles.
        tick(TMO - 1);
        chk("tmo14_err", {31'd0, fetch_err}, 32'd0);
        chk("tmo14_req", {31'd0, mem_req}, 32'd1);
        tick();
        chk("tmo_err", {31'd0, fetch_err}, 32'd1);
        chk("tmo_req", {31'd0, mem_req}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        tick(3);
        mem_ack = 1'b0;
        chk("err_ir", {16'd0, ir}, 32'h0000);
        chk("err_valid", {31'd0, ir_valid}, 32'd0);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream stage of the control unit: owns the PC, fetches 16-bit instructions from instruction memory over a req/ack handshake, and holds IR stable for decode.
- Also holds the 4-bit status register (V,C,N,Z) that the control unit consumes for BRZ/BRN.
- Applies PC redirects (branch/jump target) on instruction completion.
- Detects memory timeouts and parks in an error state.

Parameters:
- PC_WIDTH, 16, PC and memory address width.
- RESET_PC, 16'h0000, PC value loaded on reset.
- MEM_TIMEOUT, 15, max cycles mem_req may wait for mem_ack before fault (1..255).

Ports:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_req  out  1  instruction read request.
- mem_addr  out  PC_WIDTH  read address (equals pc while mem_req=1).
- mem_ack  in  1  read data valid this cycle.
- mem_rdata  in  16  instruction word.
- ir  out  16  instruction register, to control unit.
- ir_valid  out  1  ir holds an instruction awaiting execution.
- pc  out  PC_WIDTH  current PC (address of next fetch).
- ex_done  in  1  datapath finished the instruction in ir.
- pc_load  in  1  with ex_done: redirect PC.
- pc_target  in  PC_WIDTH  redirect target.
- halt  in  1  with ex_done: stop fetching.
- flags_in  in  4  V,C,N,Z from function unit.
- status_we  in  1  latch flags_in.
- status  out  4  registered status, to control unit.
- fetch_err  out  1  sticky timeout fault.
- halted  out  1  in HALT state.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, pc=RESET_PC, ir=16'h0000, status=4'b0000, timeout counter=0.
  - All outputs 0 except pc.
  - mem_req drops immediately, even mid-handshake.
- States: IDLE, REQ, ISSUE, HALT, ERR. Outputs are registered, except that mem_req and mem_addr are decoded from state.
- IDLE: unconditionally -> REQ next cycle. Gives one dead cycle after reset release.
- REQ:
  - mem_req=1, mem_addr=pc; counter increments each cycle.
  - On mem_ack: ir<=mem_rdata, pc<=pc+1 (mod 2^PC_WIDTH, 16'hFFFF wraps to 0), counter<=0, -> ISSUE.
  - Fetch latency is 1 cycle from ack to ir_valid=1; minimum REQ->ISSUE is 1 cycle (ack on first REQ cycle).
  - Timeout: if the counter reaches MEM_TIMEOUT without ack, fetch_err<=1 and -> ERR.
  - Ack on the same cycle as timeout: ack wins, no error.
- ISSUE:
  - ir_valid=1; ir and pc held stable until ex_done.
  - On ex_done:
    - halt=1: -> HALT. pc_load is still applied if asserted.
    - Otherwise pc_load=1: pc<=pc_target. Otherwise pc unchanged (already incremented).
    - Then -> REQ; ir_valid deasserts the cycle after ex_done.
- HALT: halted=1, mem_req=0, ir_valid=0; leaves only via reset.
- ERR: fetch_err=1, mem_req=0; leaves only via reset.
- ex_done, pc_load and halt are ignored outside ISSUE.
- A late mem_ack outside REQ is ignored.
- status register:
  - status<=flags_in on any cycle with status_we=1, independent of FSM state (including HALT/ERR).
  - Visible one cycle later.
  - Flag writes from the current instruction therefore affect only the next instruction's branch decision.
- ir is never written except on ack in REQ.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE=0, REQ=1, ISSUE=2, HALT=3, ERR=4, 3 bits);
  - status bit indices (Z=0, N=1, C=2, V=3, matching control-unit status[0]=Z);
  - instruction width constant 16.
- One natural sub-module: status_reg, the 4-bit enabled register with async active-low reset.
- FSM, PC and timeout counter stay in the top module.

Test Plan:
- Reset release, mem_ack on first REQ cycle with mem_rdata=16'hC0A5 -> mem_addr=0, then ir=16'hC0A5, ir_valid=1, pc=1; ex_done -> next mem_addr=1.
- Fetch in ISSUE with pc=5; ex_done with pc_load=1, pc_target=16'h0040 -> next mem_req with mem_addr=16'h0040.
- Start at pc=16'hFFFF, ack -> pc=16'h0000; ex_done -> fetch from address 0.
- MEM_TIMEOUT=15, no ack -> fetch_err=1 after the 15th REQ cycle, mem_req=0 thereafter; ack arriving exactly on cycle 15 -> no error, ir loaded.
- status_we=1, flags_in=4'b0001 while in ISSUE -> status=4'b0001 next cycle, ir unchanged; ex_done with halt=1 -> halted=1, mem_req stays 0 for 20 cycles.
- reset_n low while mem_req=1 -> mem_req=0 in the same cycle, pc=RESET_PC, status=0; release -> IDLE then REQ.
